// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the UART bus responder.
//   - tx_state_t / rx_state_t : 3-bit FSM state encodings for the two serial paths
//   - IDLE_LEVEL              : level of the serial line between frames
//   - even_parity()           : parity bit that makes the count of ones even
// The parity states are only entered when UART_RESP_PARITY_EN is defined; in the
// default 8N1 build the encodings exist but are never reached.
package uart_bus_responder_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Transmit half of the UART responder: transmit holding register (THR), shift
// register, TX FSM and baud counter.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   wr_en         : one-cycle write request (already synchronised/edge-detected)
//   wr_data[7:0]  : byte to load into THR when wr_en is seen with tbre==1
//   tbre          : THR empty, a write will be accepted
//   tsre          : shift register empty, serial line idle
//   txd           : serial output, idle high
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1); each bit is
// held exactly CLKS_PER_BIT cycles. Optional parity: UART_RESP_PARITY_EN.
module uart_tx_shifter
  import uart_bus_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tbre,
  output logic       tsre,
  output logic       txd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t       state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      thr;
  logic [7:0]      shreg;

  // Write acceptance only happens with tbre==1 and THR->shifter transfer only
  // with tbre==0, so the two tbre updates below can never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      thr     <= '0;
      shreg   <= '0;
      tbre    <= 1'b1;
      tsre    <= 1'b1;
      txd     <= IDLE_LEVEL;
    end else begin
      if (wr_en && tbre) begin
        thr  <= wr_data;
        tbre <= 1'b0;
      end

      case (state)
        TX_IDLE: begin
          if (!tbre) begin
            shreg <= thr;
            tbre  <= 1'b1;
            tsre  <= 1'b0;
            txd   <= 1'b0;
            baud  <= BAUD_LAST;
            state <= TX_START;
          end
        end

        TX_START: begin
          if (baud == '0) begin
            baud    <= BAUD_LAST;
            bit_cnt <= '0;
            txd     <= shreg[0];
            state   <= TX_DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end

        TX_DATA: begin
          if (baud == '0) begin
            baud    <= BAUD_LAST;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RESP_PARITY_EN
              txd   <= even_parity(shreg);
              state <= TX_PARITY;
`else
              txd   <= 1'b1;
              state <= TX_STOP;
`endif
            end else begin
              txd <= shreg[bit_cnt + 3'd1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end

`ifdef UART_RESP_PARITY_EN
        TX_PARITY: begin
          if (baud == '0) begin
            baud  <= BAUD_LAST;
            txd   <= 1'b1;
            state <= TX_STOP;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif

        TX_STOP: begin
          if (baud == '0) begin
            if (!tbre) begin
              // Next byte already waiting: start bit follows the stop bit with
              // no idle gap and the line never reports empty.
              shreg <= thr;
              tbre  <= 1'b1;
              txd   <= 1'b0;
              baud  <= BAUD_LAST;
              state <= TX_START;
            end else begin
              tsre  <= 1'b1;
              txd   <= IDLE_LEVEL;
              state <= TX_IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end

        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// On-FPGA stand-in for the external UART chip on the parallel UART bus.
// Bytes written over the bus are serialised on txd; frames received on rxd are
// presented in the receive holding register (RHR) for bus reads.
// Ports:
//   clk         : single clock, all state on rising edge
//   rst         : asynchronous active-low reset
//   rdn, wrn    : bus read / write strobes, active low
//   data[7:0]   : shared bus, driven with RHR only while raw rdn==0
//   data_ready  : RHR holds an unread byte
//   tbre, tsre  : transmit holding / shift register empty
//   txd, rxd    : serial out (idle high) / serial in (asynchronous)
// Optional feature: UART_RESP_PARITY_EN adds an even parity bit in both
// directions; a receive parity mismatch discards the byte.
//
// Bus handshake: a write is the rising edge of wrn, seen after a 2-FF
// synchroniser; data must still be valid 3 clocks after wrn rises and is only
// taken when tbre==1 (otherwise silently dropped). A read is rdn low: data
// follows RHR combinationally, and the synchronised falling edge of rdn clears
// data_ready unless a received byte is loaded in that same cycle.
module uart_bus_responder
  import uart_bus_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  inout  tri   [7:0] data,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  // Synchroniser chains; stage 3 is only the previous value for edge detection.
  logic rdn_s1, rdn_s2, rdn_s3;
  logic wrn_s1, wrn_s2, wrn_s3;
  logic rxd_s1, rxd_s2, rxd_s3;

  logic wr_rise, rd_fall, rx_fall;

  rx_state_t     rx_state;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [7:0]    rhr;
  logic          rx_frame_ok;
  logic          rx_done;
`ifdef UART_RESP_PARITY_EN
  logic          rx_par;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {rdn_s1, rdn_s2, rdn_s3} <= 3'b111;
      {wrn_s1, wrn_s2, wrn_s3} <= 3'b111;
      {rxd_s1, rxd_s2, rxd_s3} <= 3'b111;
    end else begin
      {rdn_s1, rdn_s2, rdn_s3} <= {rdn, rdn_s1, rdn_s2};
      {wrn_s1, wrn_s2, wrn_s3} <= {wrn, wrn_s1, wrn_s2};
      {rxd_s1, rxd_s2, rxd_s3} <= {rxd, rxd_s1, rxd_s2};
    end
  end

  assign wr_rise = wrn_s2 & ~wrn_s3;
  assign rd_fall = ~rdn_s2 & rdn_s3;
  assign rx_fall = ~rxd_s2 & rxd_s3;

  uart_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_rise),
    .wr_data(data),
    .tbre   (tbre),
    .tsre   (tsre),
    .txd    (txd)
  );

  // Receive FSM: start bit is re-checked half a bit after the falling edge,
  // then every following bit is sampled a full bit period later (mid-bit).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
`ifdef UART_RESP_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_baud  <= HALF_LAST;
            rx_state <= RX_START;
          end
        end

        RX_START: begin
          if (rx_baud == '0) begin
            if (rxd_s2) begin
              rx_state <= RX_IDLE;   // line back high: glitch, not a start bit
            end else begin
              rx_baud  <= BAUD_LAST;
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end

        RX_DATA: begin
          if (rx_baud == '0) begin
            rx_sh[rx_bit] <= rxd_s2;
            rx_bit        <= rx_bit + 3'd1;
            rx_baud       <= BAUD_LAST;
            if (rx_bit == 3'd7) begin
`ifdef UART_RESP_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end

`ifdef UART_RESP_PARITY_EN
        RX_PARITY: begin
          if (rx_baud == '0) begin
            rx_par   <= rxd_s2;
            rx_baud  <= BAUD_LAST;
            rx_state <= RX_STOP;
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
`endif

        RX_STOP: begin
          if (rx_baud == '0) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end

        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RESP_PARITY_EN
  assign rx_frame_ok = rxd_s2 & ~(^{rx_sh, rx_par});
`else
  assign rx_frame_ok = rxd_s2;
`endif

  // A good frame completes at the mid-stop sample.
  assign rx_done = (rx_state == RX_STOP) && (rx_baud == '0) && rx_frame_ok;

  // Newest byte always overwrites RHR; a load beats a simultaneous read clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rhr        <= '0;
      data_ready <= 1'b0;
    end else if (rx_done) begin
      rhr        <= rx_sh;
      data_ready <= 1'b1;
    end else if (rd_fall) begin
      data_ready <= 1'b0;
    end
  end

  assign data = rdn ? 8'bz : rhr;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder with CLKS_PER_BIT=16. A TX monitor decodes every
// frame on txd against a queue of expected bytes; a read monitor checks the bus
// value of every read against a queue; stimulus tasks push the expectations.
`timescale 1ns/1ps
module tb_uart_bus_responder;

  localparam int C = 16;
`ifdef UART_RESP_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  // clock / reset / bus signals
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_data = 8'h00;
  tri   [7:0] data;
  logic       data_ready, tbre, tsre, txd;

  assign data = tb_oe ? tb_data : 8'bz;

  uart_bus_responder #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rdn(rdn), .wrn(wrn), .data(data),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];     // bytes expected on txd, in order
  logic [7:0] rd_q[$];      // values expected on data for each read
  int         tx_starts[$]; // cycle of each observed start bit
  logic [7:0] model_rhr = 8'h00;
  logic       model_dr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Serial frame for a byte, bit 0 first on the line.
  function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
    logic [FRAME-1:0] f;
`ifdef UART_RESP_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {1'b1, b, 1'b0};
`endif
    return f;
  endfunction

  // TX monitor: every cycle of every bit must carry the expected level with tsre low.
  initial begin : tx_mon
    logic [FRAME-1:0] bits;
    logic [7:0]       b;
    bit               ok;
    forever begin
      @(negedge clk);
      if (rst && txd === 1'b0) begin
        tx_starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: frame seen, expected none");
          b = 8'h00;
        end else begin
          b = exp_q.pop_front();
        end
        bits = frame_of(b);
        for (int k = 0; k < FRAME; k++) begin
          ok = 1'b1;
          for (int j = 0; j < C; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (txd !== bits[k] || tsre !== 1'b0) ok = 1'b0;
          end
          check($sformatf("tx_byte%02h_bit%0d", b, k), {31'd0, ok}, 32'd1);
        end
      end
    end
  end

  // Read monitor: the value on the bus in the last cycle of rdn low is checked.
  initial begin : rd_mon
    logic [7:0] last;
    logic       prev_rdn;
    last = 8'h00;
    prev_rdn = 1'b1;
    forever begin
      @(negedge clk);
      if (rdn === 1'b0) begin
        last = data;
      end else if (prev_rdn === 1'b0) begin
        if (rd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got %0h with no read pending", last);
        end else begin
          check("rd_data", {24'd0, last}, {24'd0, rd_q.pop_front()});
        end
      end
      prev_rdn = rdn;
    end
  end

  // driver tasks
  task automatic bus_write(input logic [7:0] b, input bit expect_acc);
    bit start_empty, saw_low;
    @(negedge clk);
    start_empty = tbre;
    tb_data = b;
    tb_oe   = 1'b1;
    wrn     = 1'b0;
    if (expect_acc) exp_q.push_back(b);
    repeat (2) @(negedge clk);
    wrn = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) tb_oe = 1'b0;
      if (tbre === 1'b0) saw_low = 1'b1;
    end
    check("wr_accept", {31'd0, start_empty & saw_low}, {31'd0, expect_acc});
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (!(tsre === 1'b1 && exp_q.size() == 0) && n < 4 * FRAME * C) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_lines", {29'd0, tsre, tbre, txd}, 32'd7);
    check("tx_queue_empty", exp_q.size(), 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop, input bit par_flip);
    logic [FRAME-1:0] f;
    f = frame_of(b);
    f[FRAME-1] = stop;
`ifdef UART_RESP_PARITY_EN
    if (par_flip) f[FRAME-2] = ~f[FRAME-2];
`endif
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      rxd = f[k];
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
    if (stop && !par_flip) begin
      model_rhr = b;
      model_dr  = 1'b1;
    end
  endtask

  task automatic bus_read(input int hold, input bit check_clear);
    rd_q.push_back(model_rhr);
    @(negedge clk);
    rdn = 1'b0;
    repeat (3) @(negedge clk);
    if (check_clear) check("dr_cleared_by_read", {31'd0, data_ready}, 32'd0);
    repeat (hold - 3) @(negedge clk);
    rdn = 1'b1;
    model_dr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // main stimulus
  initial begin : main
    logic [7:0] b, b2;
    int n0, s, ec, off;
    bit seen;

    repeat (4) @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_tbre", {31'd0, tbre}, 32'd1);
    check("reset_tsre", {31'd0, tsre}, 32'd1);
    check("reset_dr", {31'd0, data_ready}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single write of A5, then a few random bytes
    bus_write(8'hA5, 1'b1);
    check("tbre_after_load", {31'd0, tbre}, 32'd1);
    check("tsre_busy", {31'd0, tsre}, 32'd0);
    wait_tx_idle();
    for (int i = 0; i < 3; i++) begin
      bus_write(8'($urandom_range(0, 255)), 1'b1);
      wait_tx_idle();
    end

    // back-to-back: second accepted, third dropped while THR full
    n0 = tx_starts.size();
    bus_write(8'h01, 1'b1);
    bus_write(8'h02, 1'b1);
    bus_write(8'($urandom_range(0, 255)), 1'b0);
    wait_tx_idle();
    check("b2b_frame_count", tx_starts.size() - n0, 2);
    if (tx_starts.size() >= n0 + 2)
      check("b2b_contiguous", tx_starts[n0+1] - tx_starts[n0], FRAME * C);

    // receive: fixed 3C then random bytes, each read back
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      send_rx(b, 1'b1, 1'b0);
      check("rx_dr_set", {31'd0, data_ready}, {31'd0, model_dr});
      bus_read(5, 1'b1);
    end

    // framing error: byte discarded, flag unchanged
    send_rx(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    repeat (C) @(negedge clk);
    check("framing_err_dr", {31'd0, data_ready}, 32'd0);
    bus_read(5, 1'b0);

    // 4-cycle glitch on rxd: no byte
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * FRAME * C) @(negedge clk);
    check("glitch_dr", {31'd0, data_ready}, 32'd0);
    bus_read(5, 1'b0);

    // two frames without a read: newest wins
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    check("overrun_dr", {31'd0, data_ready}, 32'd1);
    bus_read(5, 1'b1);

    // locate the completion cycle relative to the start bit
    b = 8'($urandom_range(0, 255));
    s = 0;
    ec = 0;
    seen = 1'b0;
    fork
      send_rx(b, 1'b1, 1'b0);
      begin
        @(negedge clk);
        s = cyc;
        for (int i = 0; i < FRAME * C + 20 && !seen; i++) begin
          @(negedge clk);
          if (data_ready === 1'b1) begin
            seen = 1'b1;
            ec = cyc;
          end
        end
      end
    join
    check("rx_completion_seen", {31'd0, seen}, 32'd1);
    off = ec - s;
    bus_read(5, 1'b1);

    // read strobe landing before / on / after the completion cycle
    if (seen) begin
      for (int d = -2; d <= 2; d++) begin
        b2 = 8'($urandom_range(0, 255));
        rd_q.push_back(b2);
        fork
          send_rx(b2, 1'b1, 1'b0);
          begin
            @(negedge clk);
            repeat (off - 3 + d) @(negedge clk);
            rdn = 1'b0;
            repeat (8) @(negedge clk);
            rdn = 1'b1;
          end
        join
        repeat (3) @(negedge clk);
        model_dr = (d <= 0);
        check($sformatf("read_vs_load_d%0d", d), {31'd0, data_ready}, {31'd0, model_dr});
      end
    end

`ifdef UART_RESP_PARITY_EN
    bus_write(8'h07, 1'b1);
    wait_tx_idle();
    bus_read(5, 1'b0);
    send_rx(8'h07, 1'b1, 1'b1);
    repeat (C) @(negedge clk);
    check("parity_err_dr", {31'd0, data_ready}, 32'd0);
    bus_read(5, 1'b0);
`endif

    repeat (10) @(negedge clk);
    check("final_tx_queue", exp_q.size(), 0);
    check("final_rd_queue", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
